// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: valid/ready transmitter and an oversampling-free
// centre-sampling receiver with runtime parity (none/even/odd) and 1/2 stop bits.
module uart_core_param #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CNT_W        = 13
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop_two,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // ---------------------------------------------------------------- transmitter
  state_t               tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [IDX_W-1:0]     tx_idx, tx_idx_nxt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 tx_par, tx_par_nxt;
  logic                 tx_pen, tx_pen_nxt;
  logic                 tx_s2, tx_s2_nxt;
  logic                 tx_line_nxt;
  logic                 tx_ready_nxt;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_s2    <= 1'b0;
      TX       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_par   <= tx_par_nxt;
      tx_pen   <= tx_pen_nxt;
      tx_s2    <= tx_s2_nxt;
      TX       <= tx_line_nxt;
      tx_ready <= tx_ready_nxt;
    end
  end

  // TX next state; the line value is registered for the state being entered
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_sh_nxt    = tx_sh;
    tx_par_nxt   = tx_par;
    tx_pen_nxt   = tx_pen;
    tx_s2_nxt    = tx_s2;
    tx_line_nxt  = 1'b1;
    tx_ready_nxt = 1'b0;

    if (tx_state != S_IDLE) begin
      tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
    end

    case (tx_state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_state_nxt = S_START;
          tx_cnt_nxt   = '0;
          tx_sh_nxt    = tx_data;
          tx_par_nxt   = (^tx_data) ^ parity_odd;
          tx_pen_nxt   = parity_en;
          tx_s2_nxt    = stop_two;
          tx_line_nxt  = 1'b0;
        end else begin
          tx_ready_nxt = 1'b1;
        end
      end
      S_START: begin
        tx_line_nxt = 1'b0;
        if (tx_bit_end) begin
          tx_state_nxt = S_DATA;
          tx_idx_nxt   = '0;
          tx_line_nxt  = tx_sh[0];
        end
      end
      S_DATA: begin
        tx_line_nxt = tx_sh[0];
        if (tx_bit_end) begin
          if (tx_idx == IDX_LAST) begin
            tx_state_nxt = tx_pen ? S_PARITY : S_STOP1;
            tx_line_nxt  = tx_pen ? tx_par : 1'b1;
          end else begin
            tx_idx_nxt  = tx_idx + IDX_W'(1);
            tx_sh_nxt   = tx_sh >> 1;
            tx_line_nxt = tx_sh[1];
          end
        end
      end
      S_PARITY: begin
        tx_line_nxt = tx_par;
        if (tx_bit_end) begin
          tx_state_nxt = S_STOP1;
          tx_line_nxt  = 1'b1;
        end
      end
      S_STOP1: begin
        if (tx_bit_end) begin
          tx_state_nxt = tx_s2 ? S_STOP2 : S_IDLE;
          tx_ready_nxt = !tx_s2;
        end
      end
      S_STOP2: begin
        if (tx_bit_end) begin
          tx_state_nxt = S_IDLE;
          tx_ready_nxt = 1'b1;
        end
      end
      default: begin
        tx_state_nxt = S_IDLE;
        tx_ready_nxt = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- receiver
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  state_t               rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [IDX_W-1:0]     rx_idx, rx_idx_nxt;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
  logic                 rx_pen, rx_pen_nxt;
  logic                 rx_odd, rx_odd_nxt;
  logic                 rx_s2, rx_s2_nxt;
  logic                 rx_par_bit, rx_par_bit_nxt;
  logic                 rx_ferr_acc, rx_ferr_acc_nxt;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 rx_valid_nxt, rx_parity_err_nxt, rx_frame_err_nxt, rx_busy_nxt;
  logic                 rx_sample, rx_done, rx_ferr_new;

  assign rx_sample = (rx_state == S_START) ? (rx_cnt == CNT_HALF) : (rx_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_pen        <= 1'b0;
      rx_odd        <= 1'b0;
      rx_s2         <= 1'b0;
      rx_par_bit    <= 1'b0;
      rx_ferr_acc   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_idx        <= rx_idx_nxt;
      rx_sh         <= rx_sh_nxt;
      rx_pen        <= rx_pen_nxt;
      rx_odd        <= rx_odd_nxt;
      rx_s2         <= rx_s2_nxt;
      rx_par_bit    <= rx_par_bit_nxt;
      rx_ferr_acc   <= rx_ferr_acc_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_parity_err <= rx_parity_err_nxt;
      rx_frame_err  <= rx_frame_err_nxt;
      rx_busy       <= rx_busy_nxt;
    end
  end

  // RX next state; the start bit is re-checked at its centre, later bits one period apart
  always_comb begin
    rx_state_nxt      = rx_state;
    rx_cnt_nxt        = rx_cnt;
    rx_idx_nxt        = rx_idx;
    rx_sh_nxt         = rx_sh;
    rx_pen_nxt        = rx_pen;
    rx_odd_nxt        = rx_odd;
    rx_s2_nxt         = rx_s2;
    rx_par_bit_nxt    = rx_par_bit;
    rx_ferr_acc_nxt   = rx_ferr_acc;
    rx_data_nxt       = rx_data;
    rx_valid_nxt      = 1'b0;
    rx_parity_err_nxt = rx_parity_err;
    rx_frame_err_nxt  = rx_frame_err;
    rx_busy_nxt       = rx_busy;
    rx_done           = 1'b0;
    rx_ferr_new       = 1'b0;

    if (rx_state != S_IDLE) begin
      rx_cnt_nxt = rx_sample ? '0 : rx_cnt + CNT_W'(1);
    end

    case (rx_state)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_nxt    = S_START;
          rx_cnt_nxt      = '0;
          rx_idx_nxt      = '0;
          rx_ferr_acc_nxt = 1'b0;
          rx_pen_nxt      = parity_en;
          rx_odd_nxt      = parity_odd;
          rx_s2_nxt       = stop_two;
          rx_busy_nxt     = 1'b1;
        end
      end
      S_START: begin
        if (rx_sample) begin
          if (rx_sync) begin
            rx_state_nxt = S_IDLE;
            rx_busy_nxt  = 1'b0;
          end else begin
            rx_state_nxt = S_DATA;
            rx_idx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (rx_sample) begin
          rx_sh_nxt = {rx_sync, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == IDX_LAST) begin
            rx_state_nxt = rx_pen ? S_PARITY : S_STOP1;
          end else begin
            rx_idx_nxt = rx_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_bit_nxt = rx_sync;
          rx_state_nxt   = S_STOP1;
        end
      end
      S_STOP1: begin
        if (rx_sample) begin
          if (rx_s2) begin
            rx_ferr_acc_nxt = ~rx_sync;
            rx_state_nxt    = S_STOP2;
          end else begin
            rx_done     = 1'b1;
            rx_ferr_new = ~rx_sync;
          end
        end
      end
      S_STOP2: begin
        if (rx_sample) begin
          rx_done     = 1'b1;
          rx_ferr_new = rx_ferr_acc | ~rx_sync;
        end
      end
      default: begin
        rx_state_nxt = S_IDLE;
        rx_busy_nxt  = 1'b0;
      end
    endcase

    // frame delivery: data and both flags update together with the valid pulse
    if (rx_done) begin
      rx_state_nxt      = S_IDLE;
      rx_data_nxt       = rx_sh;
      rx_parity_err_nxt = rx_pen & (rx_par_bit ^ (^rx_sh) ^ rx_odd);
      rx_frame_err_nxt  = rx_ferr_new;
      rx_valid_nxt      = 1'b1;
      rx_busy_nxt       = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param at 16 clocks per bit, 8 data bits:
// stimulus pushes expected TX frames / RX results, monitors pop and compare.
module tb_uart_core_param;

  localparam int unsigned CPB = 16;

  logic       CLOCK_50;
  logic       reset;
  logic       parity_en, parity_odd, stop_two;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TX;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;

  logic rx_drv;
  logic loopback;
  logic tx_mon_off;

  assign RX = loopback ? TX : rx_drv;

  uart_core_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .CNT_W(5)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .stop_two(stop_two),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TX(TX),
    .RX(RX),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err),
    .rx_busy(rx_busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } tx_exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected line sequence: start, data LSB first, optional parity, stop bit(s)
  function automatic tx_exp_t mk_tx(input logic [7:0] d, input logic pen, input logic pbit,
                                    input logic s2);
    tx_exp_t e;
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    e.n = 9;
    if (pen) begin
      e.bits[e.n] = pbit;
      e.n++;
    end
    e.bits[e.n] = 1'b1;
    e.n++;
    if (s2) begin
      e.bits[e.n] = 1'b1;
      e.n++;
    end
    return e;
  endfunction

  // TX monitor: every bit must hold for exactly CPB cycles with tx_ready low
  initial begin : tx_monitor
    tx_exp_t e;
    logic bad, rbad;
    forever begin
      @(negedge CLOCK_50);
      if (!reset && !tx_mon_off && TX === 1'b0) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected_start", 32'd1, 32'd0);
        end else begin
          e = tx_q.pop_front();
          rbad = 1'b0;
          for (int i = 0; i < e.n; i++) begin
            bad = 1'b0;
            for (int c = 0; c < int'(CPB); c++) begin
              if (TX !== e.bits[i]) bad = 1'b1;
              if (tx_ready !== 1'b0) rbad = 1'b1;
              @(negedge CLOCK_50);
            end
            check($sformatf("tx_bit%0d", i), {31'd0, bad}, 32'd0);
          end
          check("tx_ready_low_frame", {31'd0, rbad}, 32'd0);
          check("tx_ready_rise", {31'd0, tx_ready}, 32'd1);
        end
      end
    end
  end

  // RX monitor
  always @(negedge CLOCK_50) begin : rx_monitor
    rx_exp_t r;
    if (!reset && rx_valid === 1'b1) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected_valid", 32'd1, 32'd0);
      end else begin
        r = rx_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, r.d});
        check("rx_parity_err", {31'd0, rx_parity_err}, {31'd0, r.pe});
        check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, r.fe});
      end
    end
  end

  task automatic tx_send(input logic [7:0] d, input logic pen, input logic podd, input logic s2,
                         input logic pbit, input logic hold, input logic push);
    int w;
    @(negedge CLOCK_50);
    parity_en  = pen;
    parity_odd = podd;
    stop_two   = s2;
    tx_data    = d;
    tx_valid   = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (w >= 1000) check("tx_ready_timeout", 32'd0, 32'd1);
    if (push) tx_q.push_back(mk_tx(d, pen, pbit, s2));
    @(negedge CLOCK_50);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    rx_drv = v;
    repeat (CPB) @(negedge CLOCK_50);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic pen, input logic podd, input logic pbit,
                          input logic stopv, input logic s2);
    @(negedge CLOCK_50);
    parity_en  = pen;
    parity_odd = podd;
    stop_two   = s2;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (pen) rx_bit(pbit);
    rx_bit(stopv);
    if (s2) rx_bit(1'b1);
    rx_drv = 1'b1;
    repeat (24) @(negedge CLOCK_50);
  endtask

  task automatic rx_expect(input logic [7:0] d, input logic pe, input logic fe);
    rx_exp_t r;
    r.d  = d;
    r.pe = pe;
    r.fe = fe;
    rx_q.push_back(r);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0 || tx_ready !== 1'b1 || rx_busy !== 1'b0)
           && w < 5000) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (w >= 5000) check("drain_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    reset      = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_two   = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    rx_drv     = 1'b1;
    loopback   = 1'b0;
    tx_mon_off = 1'b0;

    repeat (3) @(negedge CLOCK_50);
    check("reset_TX", {31'd0, TX}, 32'd1);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_err_flags", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // TX 8N1 0x55, 8E2 0x07 (parity 1), 8O1 0x07 (parity 0)
    tx_send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    tx_send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    tx_send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // held tx_valid: two frames back to back
    tx_send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tx_send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // loopback 8O2 0xA3: four ones, odd parity bit 1
    loopback = 1'b1;
    rx_expect(8'hA3, 1'b0, 1'b0);
    tx_send(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    loopback = 1'b0;

    // 8E1 0x01 with parity 0 instead of 1
    rx_expect(8'h01, 1'b1, 1'b0);
    rx_drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    check("parity_err_hold", {31'd0, rx_parity_err}, 32'd1);

    // stop bit low: data still delivered
    rx_expect(8'h5A, 1'b0, 1'b1);
    rx_drive(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("frame_err_hold", {31'd0, rx_frame_err}, 32'd1);

    // clean 8E2 0xC5 (four ones, even parity bit 0) clears both flags
    rx_expect(8'hC5, 1'b0, 1'b0);
    rx_drive(8'hC5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // false start: 5 low cycles
    @(negedge CLOCK_50);
    parity_en = 1'b0;
    stop_two  = 1'b0;
    rx_drv    = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("false_start_busy", {31'd0, rx_busy}, 32'd1);
    rx_drv = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("false_start_idle", {31'd0, rx_busy}, 32'd0);
    rx_expect(8'h30, 1'b0, 1'b0);
    rx_drive(8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // reset during TX data bit 3
    tx_mon_off = 1'b1;
    tx_send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4 * CPB + 8) @(negedge CLOCK_50);
    check("tx_mid_bit3_low", {31'd0, TX}, 32'd0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("tx_reset_line", {31'd0, TX}, 32'd1);
    check("tx_reset_ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    tx_mon_off = 1'b0;

    // reset during RX data bit 3 of an all-zero frame
    rx_drv = 1'b0;
    repeat (4 * CPB + 8) @(negedge CLOCK_50);
    check("rx_mid_busy", {31'd0, rx_busy}, 32'd1);
    rx_drv = 1'b1;
    reset  = 1'b1;
    @(negedge CLOCK_50);
    check("rx_reset_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    rx_expect(8'hFF, 1'b0, 1'b0);
    rx_drive(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    tx_send(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
